wb_copy_master: RTL

//  CSR-programmed Wishbone initiator: copies LEN 32-bit words from SRC to DST over the conbus.

---
 rtl/wb_copy_master_pkg.sv | 37 +++
 rtl/wb_copy_master.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master_pkg.sv
// Shared definitions for wb_copy_master: CSR register map, CTRL bit positions,
// FSM state encoding and the STAT word packing helper.
package wb_copy_master_pkg;

   // CSR register offsets selected by csr_a[1:0]
   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_LEN  = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // CTRL write bit positions
   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_IE    = 2;
   localparam int CTRL_CLEAR = 3;

   // Copy engine states; the *_GAP states hold cyc/stb low for one cycle after an ack
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RD_REQ = 3'd1,
      ST_RD_GAP = 3'd2,
      ST_WR_REQ = 3'd3,
      ST_WR_GAP = 3'd4,
      ST_FIN    = 3'd5
   } state_t;

   // STAT read layout: [31:16] words remaining, [4] ie, [3] aborted, [2] err, [1] done, [0] busy
   function automatic logic [31:0] pack_stat(input logic [15:0] rem,
                                             input logic        ie,
                                             input logic        aborted,
                                             input logic        err,
                                             input logic        done,
                                             input logic        busy);
      return {rem, 11'd0, ie, aborted, err, done, busy};
   endfunction

endpackage

// File: rtl/wb_copy_master.sv
// wb_copy_master: CSR-programmed Wishbone initiator that copies LEN 32-bit words
// from SRC to DST, one classic read followed by one classic write per word,
// with a single word buffered between the two beats.
module wb_copy_master
   import wb_copy_master_pkg::*;
#(
   parameter logic [3:0] csr_addr = 4'h2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic [2:0]  wb_cti_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        irq
);

   state_t      state, state_next;

   // programmed registers
   logic [31:0] src, dst;
   logic [15:0] len;
   logic        ie;

   // transfer working state
   logic [31:0] cur_src, cur_dst, buffer;
   logic [15:0] rem;
   logic        done, err, aborted, abort_pending;

   logic        busy, csr_sel, csr_wr, ctrl_wr;
   logic        start_req, abort_req, clear_req, abort_now;
   logic [31:0] csr_rdata;
   logic        unused_bits;

   assign busy      = (state != ST_IDLE);
   assign csr_sel   = (csr_a[13:10] == csr_addr);
   assign csr_wr    = csr_sel && csr_we;
   assign ctrl_wr   = csr_wr && (csr_a[1:0] == REG_CTRL);
   // start is honoured only from IDLE, abort only while busy, so start wins a combined write in IDLE
   assign start_req = ctrl_wr && csr_di[CTRL_START] && !busy;
   assign abort_req = ctrl_wr && csr_di[CTRL_ABORT] && busy;
   assign clear_req = ctrl_wr && csr_di[CTRL_CLEAR];
   assign abort_now = abort_pending || abort_req;

   assign wb_sel_o    = 4'hf;
   assign wb_cti_o    = 3'b000;
   assign irq         = done && ie;
   assign unused_bits = ^csr_a[9:2];

   // CSR read mux: selects the register addressed by csr_a[1:0]
   always_comb begin
      unique case (csr_a[1:0])
         REG_SRC:  csr_rdata = src;
         REG_DST:  csr_rdata = dst;
         REG_LEN:  csr_rdata = {16'd0, len};
         default:  csr_rdata = pack_stat(rem, ie, aborted, err, done, busy);
      endcase
   end

   // CSR register writes and registered read data
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         ie     <= 1'b0;
         csr_do <= '0;
      end else begin
         if (csr_wr) begin
            unique case (csr_a[1:0])
               REG_SRC:  if (!busy) src <= {csr_di[31:2], 2'b00};
               REG_DST:  if (!busy) dst <= {csr_di[31:2], 2'b00};
               REG_LEN:  if (!busy) len <= csr_di[15:0];
               default:  ie <= csr_di[CTRL_IE];
            endcase
         end
         csr_do <= csr_sel ? csr_rdata : '0;
      end
   end

   // State register
   always_ff @(posedge sys_clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= state_next;
   end

   // Next-state and Wishbone outputs, decoded from the current state
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      state_next = state;
      wb_cyc_o   = 1'b0;
      wb_stb_o   = 1'b0;
      wb_we_o    = 1'b0;
      wb_adr_o   = '0;
      wb_dat_o   = '0;
      unique case (state)
         ST_IDLE: begin
            if (start_req) state_next = (len == 16'd0) ? ST_FIN : ST_RD_REQ;
         end
         ST_RD_REQ: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_adr_o = cur_src;
            // err wins over a simultaneous ack; a pending abort takes effect once the beat ends
            if (wb_err_i)      state_next = ST_IDLE;
            else if (wb_ack_i) state_next = abort_now ? ST_IDLE : ST_RD_GAP;
         end
         ST_RD_GAP: begin
            state_next = abort_now ? ST_IDLE : ST_WR_REQ;
         end
         ST_WR_REQ: begin
            wb_cyc_o = 1'b1;
            wb_stb_o = 1'b1;
            wb_we_o  = 1'b1;
            wb_adr_o = cur_dst;
            wb_dat_o = buffer;
            if (wb_err_i)            state_next = ST_IDLE;
            else if (wb_ack_i) begin
               if (abort_now)        state_next = ST_IDLE;
               else if (rem == 16'd1) state_next = ST_FIN;
               else                  state_next = ST_WR_GAP;
            end
         end
         ST_WR_GAP: begin
            state_next = abort_now ? ST_IDLE : ST_RD_REQ;
         end
         ST_FIN: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Transfer datapath: addresses, remaining count, word buffer and status flags
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cur_src       <= '0;
         cur_dst       <= '0;
         buffer        <= '0;
         rem           <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         aborted       <= 1'b0;
         abort_pending <= 1'b0;
      end else begin
         if (clear_req) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (abort_req) abort_pending <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (start_req) begin
                  cur_src       <= src;
                  cur_dst       <= dst;
                  rem           <= len;
                  done          <= 1'b0;
                  err           <= 1'b0;
                  aborted       <= 1'b0;
                  abort_pending <= 1'b0;
               end
            end
            ST_RD_REQ: begin
               if (wb_err_i) begin
                  err           <= 1'b1;
                  done          <= 1'b0;
                  abort_pending <= 1'b0;
               end else if (wb_ack_i) begin
                  buffer <= wb_dat_i;
                  if (abort_now) begin
                     aborted       <= 1'b1;
                     abort_pending <= 1'b0;
                  end
               end
            end
            ST_RD_GAP, ST_WR_GAP: begin
               if (abort_now) begin
                  aborted       <= 1'b1;
                  abort_pending <= 1'b0;
               end
            end
            ST_WR_REQ: begin
               if (wb_err_i) begin
                  err           <= 1'b1;
                  done          <= 1'b0;
                  abort_pending <= 1'b0;
               end else if (wb_ack_i) begin
                  // addresses wrap modulo 2^32 without any special handling
                  cur_src <= cur_src + 32'd4;
                  cur_dst <= cur_dst + 32'd4;
                  rem     <= rem - 16'd1;
                  if (abort_now) begin
                     aborted       <= 1'b1;
                     abort_pending <= 1'b0;
                  end
               end
            end
            ST_FIN: begin
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
